sprite_fetch_persona: RTL and testbench

//   Per-pixel sprite fetch stage for person A. Sits between the VGA scan

---
 rtl/sprite_fetch_persona.sv | 210 +++++++++++++++++++++
 tb/tb_sprite_fetch_persona.sv | 209 ++++++++++++++++++++
 2 files changed

// File: rtl/sprite_fetch_persona.sv
// -----------------------------------------------------------------------------
// sprite_fetch_persona
//   Per-pixel sprite fetch stage for person A. Sits between the VGA scan
//   counters and the person-A palette. For every scanned DrawX/DrawY it tests
//   the sprite bounding box and drives the sprite ROM address. The address
//   includes the animation frame and the horizontal flip. It returns an 8-bit
//   palette index and an opaque flag. Index 0 is the transparent key.
//
// Ports
//   Clk, Reset       clock, synchronous active-high reset
//   frame_start      one-cycle pulse per video frame; latches PosX/PosY/
//                    face_left and advances the animation
//   PosX, PosY       sprite top-left corner
//   moving           1 = walk animation, 0 = idle frame
//   face_left        1 = mirror sprite horizontally
//   DrawX, DrawY     current scan position
//   pix_valid_in     DrawX/DrawY are inside the active area
//   rom_addr         registered sprite ROM address
//   rom_data         ROM read data, one cycle after rom_addr
//   index            palette index (0 when the pixel misses the sprite)
//   opaque           1 = show sprite pixel, 0 = show background
//   pix_valid_out    pix_valid_in aligned with index/opaque (3-cycle latency)
// -----------------------------------------------------------------------------
module sprite_fetch_persona #(
    parameter int SPR_W      = 32,
    parameter int SPR_H      = 48,
    parameter int N_FRAMES   = 4,
    parameter int FRAME_HOLD = 8,
    parameter int ROM_AW     = 13
) (
    input  logic              Clk,
    input  logic              Reset,
    input  logic              frame_start,
    input  logic [9:0]        PosX,
    input  logic [9:0]        PosY,
    input  logic              moving,
    input  logic              face_left,
    input  logic [9:0]        DrawX,
    input  logic [9:0]        DrawY,
    input  logic              pix_valid_in,
    output logic [ROM_AW-1:0] rom_addr,
    input  logic [7:0]        rom_data,
    output logic [7:0]        index,
    output logic              opaque,
    output logic              pix_valid_out
);

    localparam int CW = $clog2(SPR_W);
    localparam int RW = $clog2(SPR_H);
    localparam int FW = (N_FRAMES > 1) ? $clog2(N_FRAMES) : 1;
    localparam int HW = (FRAME_HOLD > 1) ? $clog2(FRAME_HOLD) : 1;

    localparam logic [FW-1:0]     FRAME_IDLE  = {FW{1'b0}};
    localparam logic [FW-1:0]     FRAME_ONE   = FW'(1);
    localparam logic [FW-1:0]     FRAME_LAST  = FW'(N_FRAMES - 1);
    localparam logic [HW-1:0]     HOLD_ZERO   = {HW{1'b0}};
    localparam logic [HW-1:0]     HOLD_ONE    = HW'(1);
    localparam logic [HW-1:0]     HOLD_LAST   = HW'(FRAME_HOLD - 1);
    localparam logic [CW-1:0]     COL_LAST    = CW'(SPR_W - 1);
    localparam logic [10:0]       SPR_W_11    = 11'(SPR_W);
    localparam logic [10:0]       SPR_H_11    = 11'(SPR_H);
    localparam logic [ROM_AW-1:0] FRAME_SIZE  = ROM_AW'(SPR_W * SPR_H);
    localparam logic [ROM_AW-1:0] ROW_STRIDE  = ROM_AW'(SPR_W);

    typedef enum logic [0:0] {
        ST_IDLE = 1'b0,
        ST_WALK = 1'b1
    } anim_state_t;

    // Shadowed placement, only updated on frame_start so the image never tears
    logic [9:0]        posx_sh_r;
    logic [9:0]        posy_sh_r;
    logic              face_sh_r;

    // Animation state
    anim_state_t       state_r;
    logic [FW-1:0]     frame_r;
    logic [HW-1:0]     hold_r;

    // Pipeline registers
    logic [ROM_AW-1:0] rom_addr_r;
    logic              hit1_r;
    logic              valid1_r;
    logic              hit2_r;
    logic              valid2_r;
    logic [7:0]        index_r;
    logic              opaque_r;
    logic              valid3_r;

    // Stage-1 combinational results
    logic [10:0]       x_ext_s;
    logic [10:0]       y_ext_s;
    logic [10:0]       px_ext_s;
    logic [10:0]       py_ext_s;
    logic              hit_s;
    logic [CW-1:0]     rx_s;
    logic [RW-1:0]     ry_s;
    logic [CW-1:0]     col_s;
    logic [ROM_AW-1:0] addr_s;

    assign rom_addr      = rom_addr_r;
    assign index         = index_r;
    assign opaque        = opaque_r;
    assign pix_valid_out = valid3_r;

    // Latch sprite placement and facing at the frame boundary
    always_ff @(posedge Clk) begin
        if (Reset) begin
            posx_sh_r <= 10'd0;
            posy_sh_r <= 10'd0;
            face_sh_r <= 1'b0;
        end else if (frame_start) begin
            posx_sh_r <= PosX;
            posy_sh_r <= PosY;
            face_sh_r <= face_left;
        end
    end

    // Animation FSM: advances only on frame_start, using moving from that cycle
    always_ff @(posedge Clk) begin
        if (Reset) begin
            state_r <= ST_IDLE;
            frame_r <= FRAME_IDLE;
            hold_r  <= HOLD_ZERO;
        end else if (frame_start) begin
            case (state_r)
                ST_IDLE: begin
                    if (moving) begin
                        state_r <= ST_WALK;
                        frame_r <= FRAME_ONE;
                        hold_r  <= HOLD_ZERO;
                    end else begin
                        state_r <= ST_IDLE;
                        frame_r <= FRAME_IDLE;
                        hold_r  <= HOLD_ZERO;
                    end
                end
                ST_WALK: begin
                    if (!moving) begin
                        state_r <= ST_IDLE;
                        frame_r <= FRAME_IDLE;
                        hold_r  <= HOLD_ZERO;
                    end else if (hold_r == HOLD_LAST) begin
                        hold_r  <= HOLD_ZERO;
                        // Walk cycle loops over frames 1..N_FRAMES-1, skipping idle
                        frame_r <= (frame_r == FRAME_LAST) ? FRAME_ONE : frame_r + FRAME_ONE;
                    end else begin
                        hold_r  <= hold_r + HOLD_ONE;
                    end
                end
                default: begin
                    state_r <= ST_IDLE;
                    frame_r <= FRAME_IDLE;
                    hold_r  <= HOLD_ZERO;
                end
            endcase
        end
    end

    // Bounding-box test and ROM address for the current scan position
    always_comb begin
        // 11-bit compare so a sprite hanging off the right/bottom edge clips
        x_ext_s  = {1'b0, DrawX};
        y_ext_s  = {1'b0, DrawY};
        px_ext_s = {1'b0, posx_sh_r};
        py_ext_s = {1'b0, posy_sh_r};
        hit_s    = pix_valid_in
                   && (x_ext_s >= px_ext_s) && (x_ext_s < px_ext_s + SPR_W_11)
                   && (y_ext_s >= py_ext_s) && (y_ext_s < py_ext_s + SPR_H_11);
        // Only the low bits matter: offsets are in range whenever hit_s is set
        rx_s     = DrawX[CW-1:0] - posx_sh_r[CW-1:0];
        ry_s     = DrawY[RW-1:0] - posy_sh_r[RW-1:0];
        if (face_sh_r) begin
            col_s = COL_LAST - rx_s;
        end else begin
            col_s = rx_s;
        end
        if (hit_s) begin
            addr_s = (ROM_AW'(frame_r) * FRAME_SIZE)
                   + (ROM_AW'(ry_s) * ROW_STRIDE)
                   + ROM_AW'(col_s);
        end else begin
            addr_s = {ROM_AW{1'b0}};
        end
    end

    // Three-stage pixel pipeline: address, ROM data, registered outputs
    always_ff @(posedge Clk) begin
        if (Reset) begin
            rom_addr_r <= {ROM_AW{1'b0}};
            hit1_r     <= 1'b0;
            valid1_r   <= 1'b0;
            hit2_r     <= 1'b0;
            valid2_r   <= 1'b0;
            index_r    <= 8'd0;
            opaque_r   <= 1'b0;
            valid3_r   <= 1'b0;
        end else begin
            rom_addr_r <= addr_s;
            hit1_r     <= hit_s;
            valid1_r   <= pix_valid_in;
            hit2_r     <= hit1_r;
            valid2_r   <= valid1_r;
            index_r    <= hit2_r ? rom_data : 8'd0;
            opaque_r   <= hit2_r && (rom_data != 8'd0);
            valid3_r   <= valid2_r;
        end
    end

endmodule

// File: tb/tb_sprite_fetch_persona.sv
// -----------------------------------------------------------------------------
// tb_sprite_fetch_persona
//   Directed bench for sprite_fetch_persona. The sprite ROM is modelled as a
//   synchronous memory whose content equals the low 8 bits of the address,
//   so every expected index below is derived by hand from the address.
//   Inputs change on the falling edge; outputs are sampled on the falling edge.
// -----------------------------------------------------------------------------
module tb_sprite_fetch_persona;

    logic        Clk = 1'b0;
    logic        Reset;
    logic        frame_start;
    logic [9:0]  PosX;
    logic [9:0]  PosY;
    logic        moving;
    logic        face_left;
    logic [9:0]  DrawX;
    logic [9:0]  DrawY;
    logic        pix_valid_in;
    logic [12:0] rom_addr;
    logic [7:0]  rom_data;
    logic [7:0]  index;
    logic        opaque;
    logic        pix_valid_out;

    int n_cmp = 0;
    int n_err = 0;

    sprite_fetch_persona dut (
        .Clk           (Clk),
        .Reset         (Reset),
        .frame_start   (frame_start),
        .PosX          (PosX),
        .PosY          (PosY),
        .moving        (moving),
        .face_left     (face_left),
        .DrawX         (DrawX),
        .DrawY         (DrawY),
        .pix_valid_in  (pix_valid_in),
        .rom_addr      (rom_addr),
        .rom_data      (rom_data),
        .index         (index),
        .opaque        (opaque),
        .pix_valid_out (pix_valid_out)
    );

    always #5 Clk = ~Clk;

    // Synchronous ROM, one-cycle latency, content = address[7:0]
    always @(posedge Clk) rom_data <= rom_addr[7:0];

    task automatic check(input string tag, input int obs, input int exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    // Present one scan position for one cycle
    task automatic px(input int x, input int y, input logic v);
        DrawX        = 10'(x);
        DrawY        = 10'(y);
        pix_valid_in = v;
        @(negedge Clk);
    endtask

    // One frame_start pulse carrying new placement and movement
    task automatic pulse(input int x, input int y, input logic fl, input logic mv);
        frame_start  = 1'b1;
        PosX         = 10'(x);
        PosY         = 10'(y);
        face_left    = fl;
        moving       = mv;
        pix_valid_in = 1'b0;
        @(negedge Clk);
        frame_start  = 1'b0;
    endtask

    initial begin
        Reset        = 1'b1;
        frame_start  = 1'b0;
        PosX         = 10'd0;
        PosY         = 10'd0;
        moving       = 1'b0;
        face_left    = 1'b0;
        DrawX        = 10'd5;
        DrawY        = 10'd5;
        pix_valid_in = 1'b1;

        // Reset held two cycles over a pixel that would hit the sprite
        for (int i = 0; i < 2; i++) begin
            @(negedge Clk);
            check("rst_addr",   int'(rom_addr), 0);
            check("rst_index",  int'(index), 0);
            check("rst_opaque", int'(opaque), 0);
            check("rst_pvo",    int'(pix_valid_out), 0);
        end
        Reset = 1'b0;
        @(negedge Clk);
        check("rel1_addr",  int'(rom_addr), 165);
        check("rel1_index", int'(index), 0);
        check("rel1_pvo",   int'(pix_valid_out), 0);
        @(negedge Clk);
        check("rel2_index", int'(index), 0);
        check("rel2_pvo",   int'(pix_valid_out), 0);
        @(negedge Clk);
        check("rel3_index",  int'(index), 165);
        check("rel3_opaque", int'(opaque), 1);
        check("rel3_pvo",    int'(pix_valid_out), 1);

        // Basic addressing and miss
        pulse(100, 50, 1'b0, 1'b0);
        px(100, 50, 1'b1);
        check("addr_tl", int'(rom_addr), 0);
        px(131, 97, 1'b1);
        check("addr_br", int'(rom_addr), 1535);
        px(132, 50, 1'b1);
        check("addr_miss", int'(rom_addr), 0);
        check("zero_index",  int'(index), 0);
        check("zero_opaque", int'(opaque), 0);
        check("zero_pvo",    int'(pix_valid_out), 1);
        px(0, 0, 1'b0);
        check("br_index",  int'(index), 255);
        check("br_opaque", int'(opaque), 1);
        px(0, 0, 1'b0);
        check("miss_index",  int'(index), 0);
        check("miss_opaque", int'(opaque), 0);
        check("miss_pvo",    int'(pix_valid_out), 1);

        // Non-zero ROM data arrives exactly three cycles after the pixel
        px(105, 50, 1'b1);
        check("addr_5", int'(rom_addr), 5);
        check("lat_pvo0", int'(pix_valid_out), 0);
        px(0, 0, 1'b0);
        check("lat_early_index", int'(index), 0);
        check("lat_early_pvo",   int'(pix_valid_out), 0);
        px(0, 0, 1'b0);
        check("lat_index",  int'(index), 5);
        check("lat_opaque", int'(opaque), 1);
        check("lat_pvo",    int'(pix_valid_out), 1);

        // Horizontal flip, then placement changes without a pulse
        pulse(100, 50, 1'b1, 1'b0);
        px(100, 50, 1'b1);
        check("flip_tl", int'(rom_addr), 31);
        px(131, 50, 1'b1);
        check("flip_tr", int'(rom_addr), 0);
        px(101, 51, 1'b1);
        check("flip_r1", int'(rom_addr), 62);
        PosX      = 10'd300;
        PosY      = 10'd200;
        face_left = 1'b0;
        moving    = 1'b1;
        px(100, 50, 1'b1);
        check("noshadow_tl", int'(rom_addr), 31);
        px(300, 200, 1'b1);
        check("noshadow_new", int'(rom_addr), 0);

        // Walk animation
        pulse(100, 50, 1'b0, 1'b1);
        px(100, 50, 1'b1);
        check("walk_f1", int'(rom_addr), 1536);
        for (int i = 0; i < 7; i++) pulse(100, 50, 1'b0, 1'b1);
        px(100, 50, 1'b1);
        check("walk_f1_hold", int'(rom_addr), 1536);
        pulse(100, 50, 1'b0, 1'b1);
        px(100, 50, 1'b1);
        check("walk_f2", int'(rom_addr), 3072);
        for (int i = 0; i < 8; i++) pulse(100, 50, 1'b0, 1'b1);
        px(100, 50, 1'b1);
        check("walk_f3", int'(rom_addr), 4608);
        for (int i = 0; i < 8; i++) pulse(100, 50, 1'b0, 1'b1);
        px(100, 50, 1'b1);
        check("walk_wrap_f1", int'(rom_addr), 1536);
        pulse(100, 50, 1'b0, 1'b0);
        px(100, 50, 1'b1);
        check("walk_stop_f0", int'(rom_addr), 0);

        // Screen-edge clipping and back-to-back throughput
        pulse(620, 470, 1'b0, 1'b0);
        for (int i = 0; i < 6; i++) begin
            px((i < 4) ? 636 + i : 0, 470, (i < 4));
            if (i < 4) check("b2b_addr", int'(rom_addr), 16 + i);
            if (i >= 2) begin
                check("b2b_index", int'(index), 16 + i - 2);
                check("b2b_pvo",   int'(pix_valid_out), 1);
            end
        end
        px(639, 479, 1'b1);
        check("edge_addr", int'(rom_addr), 307);
        for (int i = 0; i < 12; i++) begin
            px(i, 479, 1'b1);
            check("clip_addr", int'(rom_addr), 0);
            if (i == 1) begin
                check("edge_index",  int'(index), 51);
                check("edge_opaque", int'(opaque), 1);
            end
            if (i >= 2) begin
                check("clip_index",  int'(index), 0);
                check("clip_opaque", int'(opaque), 0);
            end
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
